// File: rtl/template_match_scheduler_if.sv
// Bus bundle between the template match scheduler and its environment:
// run control/results, template memory read port and MAC handshake.
interface template_match_scheduler_if #(
  parameter int D_Len    = 32,
  parameter int Ele_Num  = 8,
  parameter int Num_Tmpl = 4
);
  localparam int AW = (Num_Tmpl > 1) ? $clog2(Num_Tmpl) : 1;
  localparam int VW = D_Len * Ele_Num;

  logic             start;
  logic [VW-1:0]    probe;
  logic [D_Len-1:0] threshold;
  logic             tmpl_rd_en;
  logic [AW-1:0]    tmpl_addr;
  logic [VW-1:0]    tmpl_rd_data;
  logic             mac_start;
  logic [VW-1:0]    mac_v1;
  logic [VW-1:0]    mac_v2;
  logic [D_Len-1:0] mac_result;
  logic             mac_done;
  logic             busy;
  logic             done;
  logic [AW-1:0]    best_idx;
  logic [D_Len-1:0] best_score;
  logic             match;
  logic             err;

  // Scheduler side: masters the template memory and the MAC.
  modport master (
    input  start, probe, threshold, tmpl_rd_data, mac_result, mac_done,
    output tmpl_rd_en, tmpl_addr, mac_start, mac_v1, mac_v2,
           busy, done, best_idx, best_score, match, err
  );

  // Environment side: host, template memory and MAC unit.
  modport slave (
    output start, probe, threshold, tmpl_rd_data, mac_result, mac_done,
    input  tmpl_rd_en, tmpl_addr, mac_start, mac_v1, mac_v2,
           busy, done, best_idx, best_score, match, err
  );
endinterface

// File: rtl/template_match_scheduler.sv
// Sequences one probe against every enrolled template through an external
// MAC, keeps the best FP32 score and flags a match against a threshold.
module template_match_scheduler #(
  parameter int D_Len    = 32,
  parameter int Ele_Num  = 8,
  parameter int Num_Tmpl = 4,
  parameter int Timeout  = 1024
) (
  input logic                         clk,
  input logic                         rst,
  template_match_scheduler_if.master  bus
);
  localparam int AW = (Num_Tmpl > 1) ? $clog2(Num_Tmpl) : 1;
  localparam int VW = D_Len * Ele_Num;
  localparam int CW = $clog2(Timeout + 1);
  localparam logic [AW-1:0] LAST = AW'(Num_Tmpl - 1);
  localparam logic [CW-1:0] TMO  = CW'(Timeout);

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, LAUNCH, WAIT_MAC, COMPARE, FINISH
  } state_e;

  // Maps FP32 to an unsigned key whose ordering is the numeric ordering;
  // both zeros map to the same key so +0 == -0.
  function automatic logic [D_Len-1:0] fp_key(input logic [D_Len-1:0] x);
    if (x[D_Len-2:0] == '0)  return {1'b1, {(D_Len-1){1'b0}}};
    else if (x[D_Len-1])     return ~x;
    else                     return {1'b1, x[D_Len-2:0]};
  endfunction

  state_e           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [VW-1:0]    probe_q, probe_d;
  logic [VW-1:0]    tmpl_q, tmpl_d;
  logic [D_Len-1:0] thr_q, thr_d;
  logic [D_Len-1:0] score_q, score_d;
  logic [AW-1:0]    best_idx_q, best_idx_d;
  logic [D_Len-1:0] best_score_q, best_score_d;
  logic             match_q, match_d;
  logic             err_q, err_d;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      probe_q      <= '0;
      tmpl_q       <= '0;
      thr_q        <= '0;
      score_q      <= '0;
      best_idx_q   <= '0;
      best_score_q <= '0;
      match_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      probe_q      <= probe_d;
      tmpl_q       <= tmpl_d;
      thr_q        <= thr_d;
      score_q      <= score_d;
      best_idx_q   <= best_idx_d;
      best_score_q <= best_score_d;
      match_q      <= match_d;
      err_q        <= err_d;
    end
  end

  // Next-state and datapath update; match is resolved on the way into
  // FINISH so it is valid alongside the done pulse.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    probe_d      = probe_q;
    tmpl_d       = tmpl_q;
    thr_d        = thr_q;
    score_d      = score_q;
    best_idx_d   = best_idx_q;
    best_score_d = best_score_q;
    match_d      = match_q;
    err_d        = err_q;
    case (state_q)
      IDLE: if (bus.start) begin
        probe_d      = bus.probe;
        thr_d        = bus.threshold;
        idx_d        = '0;
        err_d        = 1'b0;
        match_d      = 1'b0;
        best_idx_d   = '0;
        best_score_d = '0;
        state_d      = FETCH;
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        tmpl_d  = bus.tmpl_rd_data;
        state_d = LAUNCH;
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = WAIT_MAC;
      end
      WAIT_MAC: begin
        if (bus.mac_done) begin
          score_d = bus.mac_result;
          state_d = COMPARE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_d == TMO) begin
            err_d   = 1'b1;
            match_d = 1'b0;
            state_d = FINISH;
          end
        end
      end
      COMPARE: begin
        // Strictly-greater replacement keeps the lower index on ties.
        if (idx_q == '0 || fp_key(score_q) > fp_key(best_score_q)) begin
          best_score_d = score_q;
          best_idx_d   = idx_q;
        end
        if (idx_q == LAST) begin
          match_d = (fp_key(best_score_d) >= fp_key(thr_q));
          state_d = FINISH;
        end else begin
          idx_d   = idx_q + AW'(1);
          state_d = FETCH;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.tmpl_rd_en = (state_q == FETCH);
  assign bus.tmpl_addr  = (state_q == FETCH) ? idx_q : '0;
  assign bus.mac_start  = (state_q == LAUNCH);
  assign bus.mac_v1     = probe_q;
  assign bus.mac_v2     = tmpl_q;
  assign bus.busy       = (state_q != IDLE) && (state_q != FINISH);
  assign bus.done       = (state_q == FINISH);
  assign bus.best_idx   = best_idx_q;
  assign bus.best_score = best_score_q;
  assign bus.match      = match_q;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_template_match_scheduler.sv
// Randomized bench: template memory + MAC environment and a score/latency
// reference model derived from the matching rules.
module tb_template_match_scheduler;
  localparam int D   = 32;
  localparam int E   = 8;
  localparam int N   = 4;
  localparam int TMO = 16;
  localparam int VW  = D * E;
  localparam int AW  = 2;

  logic clk, rst;
  template_match_scheduler_if #(.D_Len(D), .Ele_Num(E), .Num_Tmpl(N)) ifc ();
  template_match_scheduler #(.D_Len(D), .Ele_Num(E), .Num_Tmpl(N), .Timeout(TMO))
    dut (.clk(clk), .rst(rst), .bus(ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;

  task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Numeric FP32 ordering by sign and magnitude, zeros of either sign equal.
  function automatic bit fge(input logic [31:0] a, input logic [31:0] b);
    bit az, bz, sa, sb;
    az = (a[30:0] == 0); bz = (b[30:0] == 0);
    if (az && bz) return 1'b1;
    sa = a[31] && !az; sb = b[31] && !bz;
    if (sa != sb) return !sa;
    if (!sa) return a[30:0] >= b[30:0];
    return a[30:0] <= b[30:0];
  endfunction

  function automatic bit fgt(input logic [31:0] a, input logic [31:0] b);
    return !fge(b, a);
  endfunction

  function automatic logic [31:0] rnd_fp();
    logic [31:0] x;
    case ($urandom_range(0, 5))
      0: x = 32'h0000_0000;
      1: x = 32'h8000_0000;
      2: x = 32'h3F80_0000;
      3: x = 32'hBF80_0000;
      default: begin
        x = $urandom;
        if (x[30:23] == 8'hFF) x[30] = 1'b0;
      end
    endcase
    return x;
  endfunction

  // Environment state shared with the tasks.
  logic [VW-1:0] mem [N];
  logic [31:0]   res [N];
  logic [VW-1:0] exp_probe;
  int lat = 0, hang = -1, wcnt = -1, nlaunch = 0, pend = 0;
  bit spur = 1'b0;
  logic s_rd, s_ms, s_rst;
  logic [AW-1:0] s_addr;
  logic [VW-1:0] s_v1, s_v2;

  // Template memory (one-cycle read) and MAC model: done arrives lat+1
  // cycles after mac_start, never for the hang index, and optionally a
  // bogus done is flashed during the launch cycle itself.
  always @(posedge clk) begin
    s_rd = ifc.tmpl_rd_en; s_addr = ifc.tmpl_addr; s_ms = ifc.mac_start;
    s_rst = rst; s_v1 = ifc.mac_v1; s_v2 = ifc.mac_v2;
    #1;
    ifc.mac_done   = 1'b0;
    ifc.mac_result = '0;
    if (s_rd) ifc.tmpl_rd_data = mem[s_addr];
    if (s_rst) wcnt = -1;
    else if (s_ms) begin
      chk("mac_v1", s_v1, exp_probe);
      if (nlaunch < N) chk("mac_v2", s_v2, mem[nlaunch]);
      pend = nlaunch;
      wcnt = (nlaunch == hang) ? -1 : lat;
      nlaunch++;
    end else if (wcnt >= 0) wcnt--;
    if (wcnt == 0 && pend < N) begin
      ifc.mac_done   = 1'b1;
      ifc.mac_result = res[pend];
    end
    if (spur && ifc.mac_start) begin
      ifc.mac_done   = 1'b1;
      ifc.mac_result = 32'h7F7F_FFFF;
    end
  end

  task automatic set4(input logic [31:0] a, b, c, d);
    res[0] = a; res[1] = b; res[2] = c; res[3] = d;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".busy"},       VW'(ifc.busy),       '0);
    chk({tag, ".done"},       VW'(ifc.done),       '0);
    chk({tag, ".mac_start"},  VW'(ifc.mac_start),  '0);
    chk({tag, ".tmpl_rd_en"}, VW'(ifc.tmpl_rd_en), '0);
    chk({tag, ".tmpl_addr"},  VW'(ifc.tmpl_addr),  '0);
    chk({tag, ".best_idx"},   VW'(ifc.best_idx),   '0);
    chk({tag, ".best_score"}, VW'(ifc.best_score), '0);
    chk({tag, ".match"},      VW'(ifc.match),      '0);
    chk({tag, ".err"},        VW'(ifc.err),        '0);
  endtask

  // Issues one run from the current negedge and checks it against the model.
  task automatic run(input string tag, input logic [31:0] thr, input bit extra);
    logic [VW-1:0] pr;
    logic [31:0] ebest;
    int cyc, eidx, ncomp, ecyc, elaunch;
    bit eerr, em;
    for (int k = 0; k < VW/32; k++) pr[k*32 +: 32] = $urandom;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < VW/32; k++) mem[i][k*32 +: 32] = $urandom;
    exp_probe = pr;
    nlaunch   = 0;
    eerr  = (hang >= 0);
    ncomp = eerr ? hang : N;
    ebest = '0; eidx = 0;
    for (int i = 0; i < ncomp; i++)
      if (i == 0 || fgt(res[i], ebest)) begin ebest = res[i]; eidx = i; end
    em      = !eerr && fge(ebest, thr);
    ecyc    = eerr ? hang*(5+lat) + 4 + TMO : N*(5+lat) + 1;
    elaunch = eerr ? hang + 1 : N;

    ifc.probe = pr; ifc.threshold = thr; ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0; ifc.probe = ~pr; ifc.threshold = ~thr;
    chk({tag, ".busy_run"}, VW'(ifc.busy), VW'(1'b1));
    cyc = 1;
    while (ifc.done !== 1'b1 && cyc < 400) begin
      ifc.start = extra && (cyc == 3);
      @(negedge clk);
      cyc++;
    end
    ifc.start = 1'b0;
    chk({tag, ".done"},       VW'(ifc.done),       VW'(1'b1));
    chk({tag, ".latency"},    VW'(cyc),            VW'(ecyc));
    chk({tag, ".best_idx"},   VW'(ifc.best_idx),   VW'(eidx));
    chk({tag, ".best_score"}, VW'(ifc.best_score), VW'(ebest));
    chk({tag, ".match"},      VW'(ifc.match),      VW'(em));
    chk({tag, ".err"},        VW'(ifc.err),        VW'(eerr));
    chk({tag, ".busy_fin"},   VW'(ifc.busy),       '0);
    chk({tag, ".launches"},   VW'(nlaunch),        VW'(elaunch));
    @(negedge clk);
    chk({tag, ".done_once"},  VW'(ifc.done),       '0);
    chk({tag, ".hold_score"}, VW'(ifc.best_score), VW'(ebest));
    chk({tag, ".hold_match"}, VW'(ifc.match),      VW'(em));
  endtask

  initial begin
    rst = 1'b1;
    ifc.start = 1'b0; ifc.probe = '0; ifc.threshold = '0;
    exp_probe = '0;
    set4(0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk_zero("reset");
    chk("reset.mac_v1", ifc.mac_v1, '0);
    rst = 1'b0;

    lat = 2; spur = 0; hang = -1;
    set4(32'h4210_0000, 32'h4290_0000, 32'hC1A0_0000, 32'h4290_0000);
    run("basic", 32'h4248_0000, 0);

    set4(32'hC1A0_0000, 32'hBF80_0000, 32'hC100_0000, 32'hC0A0_0000);
    run("neg", 32'h0000_0000, 0);

    lat = 0; spur = 1;
    set4(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
    run("negzero", 32'h0000_0000, 0);

    lat = 1; spur = 0; hang = 2;
    set4(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000);
    run("timeout", 32'h0000_0000, 0);

    lat = 3; hang = -1;
    set4(32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 32'h4040_0000);
    run("restart", 32'h4040_0000, 1);

    // Reset during WAIT_MAC, then a run accepted in the first IDLE cycle.
    hang = 2; lat = 3;
    exp_probe = 256'h5A; nlaunch = 0;
    ifc.probe = 256'h5A; ifc.threshold = 32'h0; ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    for (int c = 0; c < 100 && nlaunch < 3; c++) @(negedge clk);
    chk("midrst.reach_wait", VW'(nlaunch), VW'(3));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("midrst");
    rst = 1'b0;
    hang = -1; lat = 1;
    set4(32'hC000_0000, 32'h3F00_0000, 32'h3F00_0000, 32'h0000_0000);
    run("postrst", 32'h3F00_0000, 0);

    for (int r = 0; r < 30; r++) begin
      logic [31:0] thr;
      for (int i = 0; i < N; i++) res[i] = rnd_fp();
      lat  = $urandom_range(0, 6);
      spur = $urandom_range(0, 1);
      hang = ($urandom_range(0, 4) == 0) ? $urandom_range(1, N-1) : -1;
      thr  = ($urandom_range(0, 1) == 0) ? rnd_fp() : res[$urandom_range(0, N-1)];
      run($sformatf("rnd%0d", r), thr, $urandom_range(0, 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/template_match_scheduler.md
TEMPLATE_MATCH_SCHEDULER -- requirements
Module: template_match_scheduler

Interface
REQ-001 SHALL have parameter D_Len, default 32, FP32 element width in bits.
REQ-002 SHALL have parameter Ele_Num, default 8, elements per embedding vector.
REQ-003 SHALL have parameter Num_Tmpl, default 4, number of enrolled templates (>=1).
REQ-004 SHALL have parameter Timeout, default 1024, max cycles waited for mac_done.
REQ-005 SHALL have ports:
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request one match run.
- probe  in  D_Len*Ele_Num  probe embedding, element i at [i*D_Len +: D_Len].
- threshold  in  D_Len  FP32 match threshold.
- tmpl_rd_en  out  1  template memory read strobe.
- tmpl_addr  out  clog2(Num_Tmpl) (min 1)  template index.
- tmpl_rd_data  in  D_Len*Ele_Num  template data, valid the cycle after tmpl_rd_en.
- mac_start  out  1  one-cycle start to MAC.
- mac_v1, mac_v2  out  D_Len*Ele_Num  MAC operands (probe, template).
- mac_result  in  D_Len  FP32 dot product.
- mac_done  in  1  MAC completion.
- busy  out  1  run in progress.
- done  out  1  one-cycle run-complete pulse.
- best_idx  out  clog2(Num_Tmpl)  index of highest score.
- best_score  out  D_Len  highest FP32 score.
- match  out  1  best_score >= threshold.
- err  out  1  MAC timeout occurred in last run.

Function
REQ-006 SHALL implement states IDLE, FETCH, LOAD, LAUNCH, WAIT_MAC, COMPARE, FINISH.
REQ-007 IDLE: start=1 SHALL latch probe and threshold, clear idx to 0, clear err, go FETCH; busy=1 from the next cycle.
REQ-008 start SHALL be ignored in every state except IDLE.
REQ-009 FETCH: tmpl_rd_en=1, tmpl_addr=idx for exactly one cycle, go LOAD.
REQ-010 LOAD: capture tmpl_rd_data into template register, go LAUNCH.
REQ-011 LAUNCH: mac_start=1 for exactly one cycle, clear timeout counter, go WAIT_MAC.
REQ-012 mac_v1 SHALL equal latched probe and mac_v2 the template register, both stable from LAUNCH through end of WAIT_MAC.
REQ-013 WAIT_MAC: mac_done sampled only here; mac_done during LAUNCH SHALL be ignored; on mac_done=1 capture mac_result, go COMPARE.
REQ-014 WAIT_MAC: counter increments each cycle; reaching Timeout without mac_done SHALL set err=1, match=0, go FINISH, leaving best_idx/best_score at values so far.
REQ-015 COMPARE: idx 0 SHALL load best unconditionally; later idx SHALL replace best only if score strictly greater (ties keep lower index).
REQ-016 COMPARE: idx==Num_Tmpl-1 -> FINISH; else idx+1 -> FETCH.
REQ-017 FP32 compare: sign-magnitude ordering; +0 and -0 equal; inputs assumed non-NaN.
REQ-018 FINISH: match = (best_score >= latched threshold) unless err; done=1 one cycle; busy=0; go IDLE.
REQ-019 best_idx, best_score, match, err SHALL hold until next accepted start.
REQ-020 Per-template latency SHALL be 4 cycles + MAC latency (FETCH, LOAD, LAUNCH, COMPARE); done SHALL assert one cycle after the final COMPARE.

Reset
REQ-021 rst=1 SHALL force IDLE, and zero busy, done, mac_start, tmpl_rd_en, tmpl_addr, best_idx, best_score, match, err, counters and internal registers, on the next edge, including mid-run.
REQ-022 After rst deasserts, start SHALL be accepted in the first IDLE cycle.

Verification
REQ-023 Num_Tmpl=4, bench MAC model returns 36.0 (0x42100000), 72.0 (0x42900000), -20.0 (0xC1A00000), 72.0 in order, threshold 50.0 (0x42480000) -> best_idx=1, best_score=0x42900000, match=1, err=0, single done pulse.
REQ-024 Results -20.0, -1.0 (0xBF800000), -8.0, -5.0, threshold 0x00000000 -> best_idx=1, best_score=0xBF800000, match=0.
REQ-025 All results 0x80000000 (-0), threshold 0x00000000 -> best_idx=0, match=1.
REQ-026 MAC model never asserts mac_done for template 2, Timeout=16 -> err=1, match=0, done 16 cycles after WAIT_MAC entry, best_idx from templates 0-1.
REQ-027 start pulsed while busy, and rst during WAIT_MAC -> second start ignored (exactly 4 mac_start pulses); after rst, all outputs 0 and a new run completes correctly.
